// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead add/subtract engine:
// controller states, the slice width and the nibble-index sizing helper.
package cla_pkg;

  // Width of the single carry-lookahead slice that is time-multiplexed.
  localparam int NIBBLE = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index nslice nibbles; never less than one bit so a
  // single-nibble engine still has a legal counter.
  function automatic int idx_width(input int nslice);
    if (nslice > 1) begin
      return $clog2(nslice);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// Four-bit carry-lookahead adder slice: generate/propagate terms with every
// internal carry expanded directly from cin so no ripple chain exists.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  // Lookahead carries and per-bit sums.
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = cin;
    c_s[1] = g_s[0] | (p_s[0] & cin);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
    s      = p_s ^ c_s[3:0];
    cout   = c_s[4];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit add/subtract engine. One cla_4bit slice is reused
// over WIDTH/4 cycles, least-significant nibble first, with the carry kept
// in a register between nibbles. Valid/ready handshakes on both sides; the
// DONE state can hand a result off and accept new operands in one cycle.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / NIBBLE;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  if (((WIDTH % NIBBLE) != 0) || (WIDTH < NIBBLE)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state_r;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             accept_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [3:0]       s_nib_s;
  logic             slice_cout_s;
  logic             ovf_s;

  // A result leaving DONE frees the engine in the same cycle, so ready
  // depends combinationally on out_ready in that state.
  assign in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s = in_valid && in_ready;

  // Operand conditioning: subtraction is a + ~b + 1, and cin is dropped.
  always_comb begin
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
  end

  // Nibble selection for the shared slice and the MSB overflow term
  // (carry into the sign bit xor carry out of it).
  always_comb begin
    a_nib_s = a_r[NIBBLE*int'(idx_r) +: NIBBLE];
    b_nib_s = b_r[NIBBLE*int'(idx_r) +: NIBBLE];
    ovf_s   = (a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ s_nib_s[3]) ^ slice_cout_s;
  end

  cla_4bit u_slice (
    .a    (a_nib_s),
    .b    (b_nib_s),
    .cin  (carry_r),
    .s    (s_nib_s),
    .cout (slice_cout_s)
  );

  // Controller: operand capture, nibble stepping, result hold and handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (accept_s) begin
      a_r         <= a;
      b_r         <= b_load_s;
      carry_r     <= carry_load_s;
      idx_r       <= '0;
      state_r     <= RUN;
      busy_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          sum_r[NIBBLE*int'(idx_r) +: NIBBLE] <= s_nib_s;
          carry_r <= slice_cout_s;
          if (idx_r == LAST_IDX) begin
            idx_r       <= '0;
            cout_r      <= slice_cout_s;
            ovf_r       <= ovf_s;
            state_r     <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        IDLE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16). A plain-arithmetic model
// predicts each result; a compare process checks every cycle out_valid is
// high, including the accept-to-result latency.
module tb_cla_seq_adder;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_ov_cyc = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           seen;
  } exp_t;

  exp_t exp_q[$];

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, tb,
                                         input logic tc, ts);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c;
    logic         v;
    bb   = ts ? ~tb : tb;
    c    = ts ? 1'b1 : tc;
    full = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, c};
    v    = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  // Present one operation and wait (bounded) for it to be accepted.
  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [W-1:0] ta, tb, input logic tc, ts);
    int   n;
    int   acc;
    logic [W+1:0] m;
    exp_t e;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    acc = cyc;
    m = model(ta, tb, tc, ts);
    e.sum = m[W-1:0]; e.cout = m[W]; e.ovf = m[W+1]; e.acc = acc; e.seen = 1'b0;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every predicted result has drained.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Compare process: every cycle a result is offered, check it and its timing.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!exp_q[0].seen) begin
          // accept edge plus NSLICE stepping edges
          chk("latency", 32'(cyc - exp_q[0].acc), 32'(NSLICE + 1));
          exp_q[0].seen = 1'b1;
          first_ov_cyc = cyc;
        end
        chk("sum", 32'(sum), 32'(exp_q[0].sum));
        chk("cout", 32'(cout), 32'(exp_q[0].cout));
        chk("ovf", 32'(ovf), 32'(exp_q[0].ovf));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("in_ready_in_done", 32'(in_ready), 32'(out_ready));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Hand-computed vectors that pin the model: a, b, cin, sub, sum, cout, ovf.
  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W-1:0] s;
    logic co, v;
  } vec_t;

  vec_t vecs[7];
  logic [W-1:0] held_sum;
  logic held_cout, held_ovf;
  int   first_done, b2b_acc, n;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    for (int i = 0; i < 7; i++) begin
      logic [W+1:0] m;
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk("model_pin", 32'(m), 32'({vecs[i].v, vecs[i].co, vecs[i].s}));
    end

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one at a time
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("in_ready_in_run", 32'(in_ready), 32'd0);
      drain();
    end

    // Backpressure: hold out_ready low for 7 cycles of out_valid
    out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", 32'({sum, cout, ovf}), 32'({held_sum, held_cout, held_ovf}));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Back-to-back: second operation accepted in the first result's DONE cycle
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    first_done = cyc + NSLICE;
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    b2b_acc = exp_q[exp_q.size()-1].acc;
    chk("b2b_no_bubble", 32'(b2b_acc), 32'(first_done));
    // in_valid pulsed during RUN must be ignored
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    @(negedge clk);
    chk("run_pulse_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN at nibble index 2
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();
    chk("post_rst_sum", 32'(sum), 32'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
